qmult_arbiter: RTL and testbench
================================

Name: qmult_arbiter

Overview:
- Shares one signed-magnitude fixed-point multiplier datapath (Q fractional bits, N total bits, MSB = sign) among NUM_REQ requesters.
- Each requester offers an operand pair through a valid/ready handshake. A round-robin arbiter grants one pair at a time and sequences it through the multiply.
- The result is returned with the requester ID and an overflow flag on a single response channel with backpressure.
- The block sits between control-loop clients (e.g. PID channels) and the shared multiplier, so only one multiplier instance is needed.

Parameters:
- Q, 15, fractional bits of operands and result
- N, 32, total word width including sign bit
- NUM_REQ, 4, number of requesters (2..16)
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NUM_REQ

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester operand-pair valid
- o_req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
- i_req_a  in  NUM_REQ*N  multiplicands, requester k at [k*N +: N]
- i_req_b  in  NUM_REQ*N  multipliers, same packing
- o_rsp_valid  out  1  result available
- i_rsp_ready  in  1  consumer accepts result
- o_rsp_id  out  IDW  index of requester that issued the operands
- o_rsp_result  out  N  signed-magnitude product
- o_rsp_ovr  out  1  magnitude overflow flag

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_ovr=0
  - operand registers=0, o_req_ready=0
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Search i_req_valid starting at rr_ptr, ascending and wrapping; the first set bit g wins.
  - o_req_ready[g]=1 combinationally in that cycle only; a transfer occurs on valid&ready.
  - Latch a_g and b_g, latch id=g, set rr_ptr=(g+1) mod NUM_REQ, go to MUL.
  - With no valid: stay in IDLE; rr_ptr unchanged.
- MUL (exactly 1 cycle):
  - mag = a[N-2:0]*b[N-2:0], width 2N-2.
  - result[N-1] = a[N-1]^b[N-1].
  - result[N-2:0] = mag[N-2+Q:Q], truncation toward zero.
  - ovr = |mag[2N-3:N-1+Q].
  - Register result, ovr and id onto the outputs; go to RESP.
- RESP:
  - o_rsp_valid=1. All o_rsp_* outputs are held stable until i_rsp_ready=1.
  - On the handshake, go to IDLE with o_rsp_valid=0 on the next cycle.
- o_req_ready is 0 in MUL and RESP. Requesters must hold valid and operands until ready.
- Latency: accept edge at cycle 0 -> o_rsp_valid at cycle 2. Minimum issue interval is 3 cycles.
- A sign bit on a zero magnitude is not normalized; -0 is passed through as produced.
- Reset asserted mid-operation aborts the transaction immediately. No response is produced and the aborted requester is not granted again until re-arbitration after reset.
- A requester dropping valid before its grant is legal and is simply not considered.
- Ties are impossible: exactly one winner per IDLE cycle.

Optional Feature:
- Macro: QMULT_ARB_SATURATE_EN.
- When defined and ovr=1: result[N-2:0] = all ones (max magnitude); the sign is unchanged. o_rsp_ovr is still 1.
- When undefined: the truncated bits mag[N-2+Q:Q] are returned on overflow, matching the plain multiplier behaviour.

Test Plan:
- Reset then single request (Q=15, N=32): req0 a=0x0000C000 (1.5), b=0x00010000 (2.0) -> o_rsp_valid 2 cycles after accept, result=0x00018000, id=0, ovr=0.
- Sign: req2 a=0x80008000 (-1.0), b=0x00010000 (2.0) -> result=0x80010000, id=2, ovr=0.
- Overflow: a=0x40000000, b=0x00040000 -> ovr=1 and result=0x00000000 without the macro; result=0x7FFFFFFF with QMULT_ARB_SATURATE_EN.
- Round robin: all four valid continuously, i_rsp_ready=1 -> grant order 0,1,2,3,0, one accept every 3 cycles, each o_rsp_id matching its operands.
- Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_* stable and o_req_ready=0 throughout; release -> o_rsp_valid drops next cycle.
- Reset mid-MUL: assert i_rst_n=0 in MUL -> all outputs 0 immediately; after release a pending req1 is served with id=1 and the aborted op produces no response.

Source files
------------

// File: rtl/qmult_arbiter.sv
// qmult_arbiter: round-robin arbiter sharing one signed-magnitude Q-format
// multiplier among NUM_REQ requesters, with a single backpressured response channel.
// Optional build macro QMULT_ARB_SATURATE_EN: clamp the magnitude to all ones on overflow.
module qmult_arbiter #(
    parameter int unsigned Q       = 15,
    parameter int unsigned N       = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [NUM_REQ*N-1:0] i_req_a,
    input  logic [NUM_REQ*N-1:0] i_req_b,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [N-1:0]         o_rsp_result,
    output logic                 o_rsp_ovr
);

    localparam int unsigned MW = 2 * N - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_reg;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] grant_next;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic [MW-1:0]  mag;
    logic [N-2:0]   res_mag;
    logic           ovr;

    // Round-robin search: first requests at or above rr_ptr, then wrap to those below it
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && i_req_valid[j] && (IDW'(j) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && i_req_valid[j] && (IDW'(j) < rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
        grant_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (IDW'(j) == grant_idx) begin
                sel_a = i_req_a[j*N +: N];
                sel_b = i_req_b[j*N +: N];
            end
        end
    end

    // Accept strobe only while idle; forced low while reset is asserted
    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && (state == IDLE) && grant_found) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    // Magnitude product, truncation toward zero and overflow detection
    always_comb begin
        mag = MW'(a_reg[N-2:0]) * MW'(b_reg[N-2:0]);
        ovr = |mag[MW-1:N-1+Q];
`ifdef QMULT_ARB_SATURATE_EN
        res_mag = ovr ? '1 : mag[N-2+Q:Q];
`else
        res_mag = mag[N-2+Q:Q];
`endif
    end

    // Arbitration / multiply / response sequencing with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_result <= '0;
            o_rsp_ovr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_reg  <= sel_a;
                        b_reg  <= sel_b;
                        id_reg <= grant_idx;
                        rr_ptr <= grant_next;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    o_rsp_result <= {a_reg[N-1] ^ b_reg[N-1], res_mag};
                    o_rsp_ovr    <= ovr;
                    o_rsp_id     <= id_reg;
                    o_rsp_valid  <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_rsp_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qmult_arbiter.sv
// Self-checking bench for qmult_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic checked by a cycle-level reference model.
module tb_qmult_arbiter;

    localparam int Q   = 15;
    localparam int N   = 32;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*N-1:0] req_a;
    logic [NR*N-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [N-1:0]    rsp_result;
    logic            rsp_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    qmult_arbiter #(.Q(Q), .N(N), .NUM_REQ(NR), .IDW(IDW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_ovr    (rsp_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product from the number format: returns {ovr, result}
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, p;
        logic [31:0] r;
        logic        ov;
        ma = 64'(a & 32'h7FFF_FFFF);
        mb = 64'(b & 32'h7FFF_FFFF);
        p  = ma * mb;
        ov = ((p >> (N - 1 + Q)) != 0);
        r  = {a[31] ^ b[31], 31'(p >> Q)};
`ifdef QMULT_ARB_SATURATE_EN
        if (ov) r[30:0] = '1;
`endif
        return {ov, r};
    endfunction

    // First valid requester at or after ptr, wrapping; -1 if none
    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int i = 0; i < NR; i++) begin
            int k = (ptr + i) % NR;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        v[30:0] = v[30:0] >> $urandom_range(0, 30);
        return v;
    endfunction

    // Reference model: one outstanding op, response two cycles after accept, held until taken
    int          m_ptr  = 0;
    bit          m_busy = 0;
    int          m_age  = 0;
    logic [1:0]  m_id   = '0;
    logic [32:0] m_exp  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovr}, '0);
            m_busy = 0;
            m_ptr  = 0;
        end else begin
            logic [NR-1:0] er;
            int            w;
            bit            ev;
            er = '0;
            w  = -1;
            if (!m_busy) begin
                w = pick(req_valid, m_ptr);
                if (w >= 0) er[w] = 1'b1;
            end
            check("req_ready", req_ready, er);
            ev = m_busy && (m_age >= 2);
            check("rsp_valid", rsp_valid, ev);
            if (ev) check("rsp_payload", {rsp_id, rsp_ovr, rsp_result}, {m_id, m_exp});
            if (w >= 0) begin
                m_busy = 1;
                m_age  = 1;
                m_id   = 2'(w);
                m_exp  = ref_mul(req_a[w*N +: N], req_b[w*N +: N]);
                m_ptr  = (w + 1) % NR;
            end else if (ev && rsp_ready) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_age++;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Single request with spec-derived expected values and latency
    task automatic run_single(input string name, input int k, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_r, input logic exp_o);
        int n;
        bit got;
        @(posedge clk); #1;
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
        req_valid[k]    = 1'b1;
        rsp_ready       = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[k]) got = 1;
        end
        check({name, "_accept"}, got, 1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        got = 0;
        n   = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1;
        end
        check({name, "_latency"}, n, 2);
        check({name, "_id"}, rsp_id, k);
        check({name, "_result"}, rsp_result, exp_r);
        check({name, "_ovr"}, rsp_ovr, exp_o);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        o;
    } vec_t;

    vec_t vt[8];

    initial begin
        int          gid[5];
        int          gcyc[5];
        int          ng;
        logic [1:0]  rid[$];
        logic [31:0] rres[$];
        logic [NR-1:0] acc;
        bit          got;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        vt[0] = '{0, 32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0};
        vt[1] = '{2, 32'h8000_8000, 32'h0001_0000, 32'h8001_0000, 1'b0};
`ifdef QMULT_ARB_SATURATE_EN
        vt[2] = '{1, 32'h4000_0000, 32'h0004_0000, 32'h7FFF_FFFF, 1'b1};
        vt[7] = '{2, 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b1};
`else
        vt[2] = '{1, 32'h4000_0000, 32'h0004_0000, 32'h0000_0000, 1'b1};
        vt[7] = '{2, 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFE, 1'b1};
`endif
        vt[3] = '{0, 32'h8000_0000, 32'h0000_1234, 32'h8000_0000, 1'b0};
        vt[4] = '{1, 32'h8000_8000, 32'h8000_4000, 32'h0000_4000, 1'b0};
        vt[5] = '{3, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vt[6] = '{3, 32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0};

        // Reset state
        @(negedge clk);
        check("reset_state", {req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovr}, '0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++)
            run_single($sformatf("vec%0d", i), vt[i].k, vt[i].a, vt[i].b, vt[i].r, vt[i].o);

        // Round robin with every requester continuously valid
        apply_reset();
        for (int k = 0; k < NR; k++) begin
            req_a[k*N +: N] = 32'((k + 1) << Q);
            req_b[k*N +: N] = 32'h0000_8000;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if ((req_ready != 0) && ng < 5) begin
                for (int k = 0; k < NR; k++) if (req_ready[k]) gid[ng] = k;
                gcyc[ng] = c;
                ng++;
            end
            if (rsp_valid && rsp_ready) begin
                rid.push_back(rsp_id);
                rres.push_back(rsp_result);
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rr_grant_count", ng, 5);
        for (int i = 0; i < 5 && i < ng; i++) check($sformatf("rr_grant%0d", i), gid[i], i % NR);
        for (int i = 1; i < 5 && i < ng; i++) check($sformatf("rr_interval%0d", i), gcyc[i] - gcyc[i-1], 3);
        check("rr_rsp_count_ge4", (rid.size() >= 4), 1);
        for (int i = 0; i < 4 && i < rid.size(); i++) begin
            check($sformatf("rr_rsp_id%0d", i), rid[i], i % NR);
            check($sformatf("rr_rsp_res%0d", i), rres[i], 32'(((i % NR) + 1) << Q));
        end

        // Backpressure: response held five cycles while another requester waits
        @(posedge clk); #1;
        req_a[1*N +: N] = 32'h0001_8000;
        req_b[1*N +: N] = 32'h8000_4000;
        req_valid[1]    = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1;
        end
        check("bp_accept", got, 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_a[3*N +: N] = 32'h0000_8000;
        req_b[3*N +: N] = 32'h0000_8000;
        req_valid[3] = 1'b1;
        rsp_ready    = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        check("bp_rsp_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("bp_hold%0d", i), {rsp_valid, rsp_id, rsp_ovr, rsp_result, req_ready},
                  {1'b1, 2'd1, 1'b0, 32'h8000_C000, 4'b0000});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_still_valid", rsp_valid, 1);
        @(negedge clk);
        check("bp_valid_drop", rsp_valid, 0);
        check("bp_next_grant", req_ready, 4'b1000);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        repeat (5) @(posedge clk);

        // Reset during MUL aborts the op; pending requester 1 is served afterwards
        #1;
        req_a[0] = 32'h0001_0000;
        req_a[0*N +: N] = 32'h0001_0000;
        req_b[0*N +: N] = 32'h0001_0000;
        req_valid[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        check("rst_accept0", got, 1);
        @(posedge clk); #1;
        rst_n        = 1'b0;
        req_valid[0] = 1'b0;
        req_a[1*N +: N] = 32'h0001_0000;
        req_b[1*N +: N] = 32'h0001_0000;
        req_valid[1] = 1'b1;
        #1;
        check("rst_immediate", {req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovr}, '0);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1;
        end
        check("rst_accept1", got, 1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        check("rst_rsp_seen", got, 1);
        check("rst_rsp_id", rsp_id, 1);
        check("rst_rsp_result", rsp_result, 32'h0002_0000);
        check("rst_rsp_ovr", rsp_ovr, 0);
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        acc = '0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NR; k++) begin
                if (acc[k]) begin
                    req_valid[k] = 1'b0;
                end else if (req_valid[k] && $urandom_range(0, 15) == 0) begin
                    req_valid[k] = 1'b0;
                end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    req_a[k*N +: N] = rand_op();
                    req_b[k*N +: N] = rand_op();
                    req_valid[k]    = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = req_ready;
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
